// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared constants, types and the CDB snoop helper for the reservation station
package reservation_station_pkg;

    localparam int OP_ENUM_WIDTH = 6;
    localparam int DATA_WIDTH    = 32;
    localparam int ADDR_WIDTH    = 32;
    localparam int ROB_ID_WIDTH  = 5;
    localparam int RS_SIZE       = 16;
    localparam int RS_ID_WIDTH   = 4;

    typedef logic [OP_ENUM_WIDTH-1:0] op_enum_t;
    typedef logic [DATA_WIDTH-1:0]    data_t;
    typedef logic [ADDR_WIDTH-1:0]    addr_t;
    typedef logic [ROB_ID_WIDTH-1:0]  rob_id_t;
    typedef logic [RS_ID_WIDTH-1:0]   rs_id_t;
    typedef logic [RS_ID_WIDTH:0]     rs_count_t;

    localparam rob_id_t ROB_ID_RESET = '0;
    localparam logic    TRUE         = 1'b1;
    localparam logic    FALSE        = 1'b0;

    typedef struct packed {
        rob_id_t q;
        data_t   v;
    } operand_t;

    typedef struct packed {
        op_enum_t op;
        operand_t src1;
        operand_t src2;
        data_t    imm;
        addr_t    inst_pos;
        rob_id_t  rob_id;
    } rs_entry_t;

    // ALU bus is checked first so it wins if both buses carry the same tag
    function automatic operand_t snoop_operand(
        input operand_t cur,
        input logic     alu_en,
        input rob_id_t  alu_id,
        input data_t    alu_res,
        input logic     lsu_en,
        input rob_id_t  lsu_id,
        input data_t    lsu_res
    );
        operand_t res;
        res = cur;
        if (cur.q != ROB_ID_RESET) begin
            if (alu_en && cur.q == alu_id) begin
                res.q = ROB_ID_RESET;
                res.v = alu_res;
            end else if (lsu_en && cur.q == lsu_id) begin
                res.q = ROB_ID_RESET;
                res.v = lsu_res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_priority_encoder.sv
// rtl/reservation_station_priority_encoder.sv - lowest-set-bit finder returning index and found flag
module rs_priority_encoder #(
    parameter int WIDTH     = 16,
    parameter int IDX_WIDTH = 4
) (
    input  logic [WIDTH-1:0]     req,
    output logic [IDX_WIDTH-1:0] index,
    output logic                 found
);

    always_comb begin
        index = '0;
        found = 1'b0;
        // Scan from the top so the lowest set bit is the last one written
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_WIDTH'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - non-memory reservation station with CDB wakeup and single ALU issue per cycle
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     enable_from_dispatcher,
    input  op_enum_t op_enum_from_dispatcher,
    input  data_t    V1_from_dispatcher,
    input  data_t    V2_from_dispatcher,
    input  rob_id_t  Q1_from_dispatcher,
    input  rob_id_t  Q2_from_dispatcher,
    input  data_t    imm_from_dispatcher,
    input  addr_t    inst_pos_from_dispatcher,
    input  rob_id_t  rob_id_from_dispatcher,
    output logic     is_full_to_dispatcher,
    input  logic     enable_from_alu,
    input  rob_id_t  rob_id_from_alu,
    input  data_t    result_from_alu,
    input  logic     enable_from_lsu,
    input  rob_id_t  rob_id_from_lsb,
    input  data_t    result_from_lsu,
    input  logic     rollback_flag_from_rob,
    output logic     enable_to_alu,
    output op_enum_t op_enum_to_alu,
    output data_t    V1_to_alu,
    output data_t    V2_to_alu,
    output data_t    imm_to_alu,
    output addr_t    inst_pos_to_alu,
    output rob_id_t  rob_id_to_alu
);

    rs_entry_t          entries [RS_SIZE];
    logic [RS_SIZE-1:0] valid;
    logic [RS_SIZE-1:0] ready;
    rs_count_t          count;
    rs_id_t             free_idx;
    rs_id_t             issue_idx;
    logic               free_found;
    logic               issue_found;
    logic               do_insert;
    rs_entry_t          incoming;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = valid[i] && entries[i].src1.q == ROB_ID_RESET
                                && entries[i].src2.q == ROB_ID_RESET;
        end
    end

    rs_priority_encoder #(.WIDTH(RS_SIZE), .IDX_WIDTH(RS_ID_WIDTH)) u_free_enc (
        .req   (~valid),
        .index (free_idx),
        .found (free_found)
    );

    rs_priority_encoder #(.WIDTH(RS_SIZE), .IDX_WIDTH(RS_ID_WIDTH)) u_issue_enc (
        .req   (ready),
        .index (issue_idx),
        .found (issue_found)
    );

    assign do_insert = enable_from_dispatcher && free_found;
    assign is_full_to_dispatcher = (count >= rs_count_t'(RS_SIZE - 1));

    // Incoming operands see this cycle's broadcasts so no wakeup is missed
    always_comb begin
        incoming.op       = op_enum_from_dispatcher;
        incoming.src1     = snoop_operand('{q: Q1_from_dispatcher, v: V1_from_dispatcher},
                                          enable_from_alu, rob_id_from_alu, result_from_alu,
                                          enable_from_lsu, rob_id_from_lsb, result_from_lsu);
        incoming.src2     = snoop_operand('{q: Q2_from_dispatcher, v: V2_from_dispatcher},
                                          enable_from_alu, rob_id_from_alu, result_from_alu,
                                          enable_from_lsu, rob_id_from_lsb, result_from_lsu);
        incoming.imm      = imm_from_dispatcher;
        incoming.inst_pos = inst_pos_from_dispatcher;
        incoming.rob_id   = rob_id_from_dispatcher;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid           <= '0;
            count           <= '0;
            enable_to_alu   <= 1'b0;
            op_enum_to_alu  <= '0;
            V1_to_alu       <= '0;
            V2_to_alu       <= '0;
            imm_to_alu      <= '0;
            inst_pos_to_alu <= '0;
            rob_id_to_alu   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                entries[i] <= '0;
            end
        end else if (!rdy_in) begin
            enable_to_alu <= 1'b0;
        end else if (rollback_flag_from_rob) begin
            valid         <= '0;
            count         <= '0;
            enable_to_alu <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid[i]) begin
                    entries[i].src1 <= snoop_operand(entries[i].src1,
                                         enable_from_alu, rob_id_from_alu, result_from_alu,
                                         enable_from_lsu, rob_id_from_lsb, result_from_lsu);
                    entries[i].src2 <= snoop_operand(entries[i].src2,
                                         enable_from_alu, rob_id_from_alu, result_from_alu,
                                         enable_from_lsu, rob_id_from_lsb, result_from_lsu);
                end
            end
            enable_to_alu <= issue_found;
            if (issue_found) begin
                op_enum_to_alu     <= entries[issue_idx].op;
                V1_to_alu          <= entries[issue_idx].src1.v;
                V2_to_alu          <= entries[issue_idx].src2.v;
                imm_to_alu         <= entries[issue_idx].imm;
                inst_pos_to_alu    <= entries[issue_idx].inst_pos;
                rob_id_to_alu      <= entries[issue_idx].rob_id;
                valid[issue_idx]   <= 1'b0;
            end
            // Free slot comes from start-of-cycle valid bits, so it never aliases the issued slot
            if (do_insert) begin
                entries[free_idx] <= incoming;
                valid[free_idx]   <= 1'b1;
            end
            count <= count + rs_count_t'(do_insert) - rs_count_t'(issue_found);
        end
    end

endmodule
